piece_fall_controller: RTL

//  Sequencer for the falling tetromino: owns the 10-bit pixel position of the active piece.

---
 rtl/piece_fall_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/piece_fall_controller.sv
// Falling-piece sequencer: applies gravity and key moves to the active piece's pixel position,
// runs the lock handshake with the saved-block store and respawns the next piece.
module piece_fall_controller #(
    parameter int          CELL        = 20,
    parameter int          SPAWN_X     = 80,
    parameter int          DROP_FRAMES = 30,
    parameter logic [7:0]  KEY_LEFT    = 8'h04,
    parameter logic [7:0]  KEY_RIGHT   = 8'h07,
    parameter logic [7:0]  KEY_DOWN    = 8'h16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        frame_tick_i,
    input  logic        key_valid_i,
    input  logic [7:0]  key_code_i,
    input  logic        bottomchecked_i,
    input  logic        leftchecked_i,
    input  logic        rightchecked_i,
    input  logic        lock_ack_i,
    output logic [9:0]  block_x_pos_o,
    output logic [9:0]  block_y_pos_o,
    output logic        lock_req_o,
    output logic        piece_new_o,
    output logic        game_over_o,
    output logic [15:0] piece_count_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPAWN  = 3'd1;
    localparam logic [2:0] ST_CHKSP  = 3'd2;
    localparam logic [2:0] ST_FALL   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_LOCK   = 3'd5;
    localparam logic [2:0] ST_OVER   = 3'd6;

    localparam logic [1:0] KP_NONE  = 2'd0;
    localparam logic [1:0] KP_LEFT  = 2'd1;
    localparam logic [1:0] KP_RIGHT = 2'd2;
    localparam logic [1:0] KP_DOWN  = 2'd3;

    localparam logic [9:0] CELL_W    = 10'(CELL);
    localparam logic [9:0] SPAWN_W   = 10'(SPAWN_X);
    localparam logic [7:0] DROP_LAST = 8'(DROP_FRAMES - 1);

    logic [2:0]  state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  grav_cnt_q, grav_cnt_d;
    logic        grav_pend_q, grav_pend_d;
    logic [1:0]  key_pend_q, key_pend_d;
    logic [15:0] count_q, count_d;
    logic        lock_req_q, lock_req_d;
    logic        piece_new_q, piece_new_d;
    logic        game_over_q, game_over_d;

    logic        active;
    logic        grav_expire;
    logic        consume_grav;
    logic        consume_key;
    logic [1:0]  key_dec;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        grav_cnt_d   = grav_cnt_q;
        grav_pend_d  = grav_pend_q;
        key_pend_d   = key_pend_q;
        count_d      = count_q;
        consume_grav = 1'b0;
        consume_key  = 1'b0;

        active      = (state_q == ST_FALL) || (state_q == ST_SETTLE);
        grav_expire = active && frame_tick_i && (grav_cnt_q == DROP_LAST);

        if (key_code_i == KEY_LEFT)       key_dec = KP_LEFT;
        else if (key_code_i == KEY_RIGHT) key_dec = KP_RIGHT;
        else if (key_code_i == KEY_DOWN)  key_dec = KP_DOWN;
        else                              key_dec = KP_NONE;

        if (active && frame_tick_i)
            grav_cnt_d = grav_expire ? 8'd0 : grav_cnt_q + 8'd1;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_i) begin
                    state_d = ST_SPAWN;
                    count_d = 16'd0;
                end
            end
            ST_SPAWN: state_d = ST_CHKSP;
            ST_CHKSP: state_d = bottomchecked_i ? ST_FALL : ST_OVER;
            ST_FALL: begin
                // Gravity has priority; a pending key simply waits for the next FALL cycle.
                if (grav_pend_q || (key_pend_q == KP_DOWN)) begin
                    consume_grav = grav_pend_q;
                    consume_key  = !grav_pend_q;
                    if (!grav_pend_q) grav_cnt_d = 8'd0;
                    if (bottomchecked_i) begin
                        y_d     = y_q + CELL_W;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (key_pend_q == KP_LEFT) begin
                    consume_key = 1'b1;
                    if (leftchecked_i) begin
                        x_d     = x_q - CELL_W;
                        state_d = ST_SETTLE;
                    end
                end else if (key_pend_q == KP_RIGHT) begin
                    consume_key = 1'b1;
                    if (rightchecked_i) begin
                        x_d     = x_q + CELL_W;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: state_d = ST_FALL;
            ST_LOCK: begin
                if (lock_ack_i) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_SPAWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (consume_grav) grav_pend_d = 1'b0;
        if (grav_expire)  grav_pend_d = 1'b1;
        if (consume_key)  key_pend_d  = KP_NONE;
        if (active && key_valid_i && (key_dec != KP_NONE)) key_pend_d = key_dec;

        // Loading on entry makes the fresh position visible alongside piece_new.
        if (state_d == ST_SPAWN) begin
            x_d         = SPAWN_W;
            y_d         = 10'd0;
            grav_cnt_d  = 8'd0;
            grav_pend_d = 1'b0;
            key_pend_d  = KP_NONE;
        end

        lock_req_d  = (state_d == ST_LOCK);
        piece_new_d = (state_d == ST_SPAWN);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            x_q         <= SPAWN_W;
            y_q         <= 10'd0;
            grav_cnt_q  <= 8'd0;
            grav_pend_q <= 1'b0;
            key_pend_q  <= KP_NONE;
            count_q     <= 16'd0;
            lock_req_q  <= 1'b0;
            piece_new_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            grav_cnt_q  <= grav_cnt_d;
            grav_pend_q <= grav_pend_d;
            key_pend_q  <= key_pend_d;
            count_q     <= count_d;
            lock_req_q  <= lock_req_d;
            piece_new_q <= piece_new_d;
            game_over_q <= game_over_d;
        end
    end

    assign block_x_pos_o = x_q;
    assign block_y_pos_o = y_q;
    assign lock_req_o    = lock_req_q;
    assign piece_new_o   = piece_new_q;
    assign game_over_o   = game_over_q;
    assign piece_count_o = count_q;

endmodule
